// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: shared FSM state type and operation codes for serial_add_sub.
package serial_add_sub_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_fa.sv
// serial_fa: combinational 1-bit full adder, the only arithmetic cell of serial_add_sub.
module serial_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder/subtractor, one result bit per clock, LSB first.
// Define SERIAL_ADD_SUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADD_SUB_OVF_EN
    output logic             carry,
    output logic             ovf
`else
    output logic             carry
`endif
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic             c, s, cout, accept, last;

    serial_fa u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (c),
        .s   (s),
        .cout(cout)
    );

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign busy   = (state == RUN);

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // The A register doubles as the accumulator: sum bits enter at the MSB as operand bits leave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            c      <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                a_sr <= a;
                b_sr <= b ^ {WIDTH{en}};
                c    <= (en == OP_SUB);
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sr <= {s, a_sr[WIDTH-1:1]};
                b_sr <= b_sr >> 1;
                c    <= cout;
                cnt  <= cnt + CNT_W'(1);
                if (last) begin
                    result <= {s, a_sr[WIDTH-1:1]};
                    carry  <= cout;
                end
            end
        end
    end

`ifdef SERIAL_ADD_SUB_OVF_EN
    // On the last bit c is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ovf <= 1'b0;
        else if (last) ovf <= c ^ cout;
    end
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and randomized checks of serial_add_sub against an arithmetic model.
// Define SERIAL_ADD_SUB_OVF_EN to also check the ovf output.
module tb_serial_add_sub;
    import serial_add_sub_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         en = OP_ADD;
    logic         busy, done, carry;
    logic [W-1:0] result;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic         ovf;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] prev_res = '0;
    logic         prev_c = 1'b0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .en    (en),
        .busy  (busy),
        .done  (done),
        .result(result),
`ifdef SERIAL_ADD_SUB_OVF_EN
        .carry (carry),
        .ovf   (ovf)
`else
        .carry (carry)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {ovf, carry, result} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic e);
        int ux = int'(x);
        int uy = int'(y);
        int sx = (ux >= 2 ** (W - 1)) ? ux - 2 ** W : ux;
        int sy = (uy >= 2 ** (W - 1)) ? uy - 2 ** W : uy;
        int r  = e ? ux - uy : ux + uy;
        int sr = e ? sx - sy : sx + sy;
        logic cy = e ? (ux >= uy) : (r >= 2 ** W);
        logic o  = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
        return {o, cy, W'(r)};
    endfunction

    // Entered just after an edge; leaves just after the done edge with start still at 'hold'.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic e,
                          input bit hold, input bit scramble,
                          input logic [W-1:0] exp_r, input logic exp_c, input logic exp_o);
        int n;
        a = x; b = y; en = e; start = 1'b1;
        @(posedge clk); #1;
        check("accept_busy", busy, 1);
        check("done_drop", done, 0);
        start = hold;
        for (n = 1; n <= W + 4; n++) begin
            if (scramble) begin
                a = W'($urandom); b = W'($urandom); en = 1'($urandom);
            end
            @(posedge clk); #1;
            if (done) break;
            check("hold_result", {prev_c, prev_res}, {carry, result});
        end
        check("latency", n, W);
        check("result", result, exp_r);
        check("carry", carry, exp_c);
        check("busy_at_done", busy, 0);
`ifdef SERIAL_ADD_SUB_OVF_EN
        check("ovf", ovf, exp_o);
`else
        if (exp_o === 1'bx) check("ovf_unused", 0, 1);
`endif
        prev_res = result;
        prev_c = carry;
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        logic [W+1:0] m;
        int pulses;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
`ifdef SERIAL_ADD_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(4'b1010, 4'b0101, OP_ADD, 0, 0, 4'b1111, 0, 0); idle_cycle();
        run_op(4'b1010, 4'b0101, OP_SUB, 0, 0, 4'b0101, 1, 1); idle_cycle();
        run_op(4'b1110, 4'b0111, OP_ADD, 0, 1, 4'b0101, 1, 0); idle_cycle();
        run_op(4'b1110, 4'b0111, OP_SUB, 1, 0, 4'b0111, 1, 1); idle_cycle();
        run_op(4'b1111, 4'b1111, OP_ADD, 0, 0, 4'b1110, 1, 0);
        run_op(4'b1111, 4'b1111, OP_SUB, 1, 1, 4'b0000, 1, 0);
        run_op(4'b0101, 4'b1110, OP_SUB, 0, 0, 4'b0111, 0, 0); idle_cycle();
        run_op(4'b0110, 4'b0011, OP_ADD, 0, 0, 4'b1001, 0, 1); idle_cycle();

        // Abort mid-operation with an asynchronous reset.
        a = 4'b0011; b = 4'b0100; en = OP_ADD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_carry", carry, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_idle", busy, 0);
        prev_res = '0;
        prev_c = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x, y;
            logic e;
            x = W'($urandom); y = W'($urandom); e = 1'($urandom);
            m = model(x, y, e);
            run_op(x, y, e, 1'($urandom), 1'($urandom), m[W-1:0], m[W], m[W+1]);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
